mips_mc_core: RTL
=================

Name: mips_mc_core

Overview:
- Parametrised multi-cycle MIPS-I subset core; successor to the single-cycle top-level datapath.
- One unified instruction/data memory port with a req/ready handshake, so memories may insert wait states.
- Internal FSM sequences FETCH/DECODE/EXEC/MEM/WB; PC, register file, IR and temporaries are internal.
- Exposes retire/trap status for the bench and SoC glue.

Parameters:
- ADDR_W, 32, memory address width; PC and effective addresses are truncated to ADDR_W bits.
- RESET_PC, 0, PC value loaded on reset (ADDR_W bits, word aligned).
- TRAP_ON_MISALIGN, 1, 1: misaligned fetch/lw/sw enters TRAP; 0: low two address bits are forced to 0.

Ports:
- CLK, input, 1, clock; all state updates on rising edge.
- RST, input, 1, reset: synchronous, active-high. Clock is CLK.
- mem_req, output, 1, memory request valid.
- mem_we, output, 1, 1 = write (sw), 0 = read; valid only while mem_req=1.
- mem_addr, output, ADDR_W, byte address, word aligned.
- mem_wdata, output, 32, store data; valid only while mem_we=1.
- mem_ready, input, 1, memory accepts/completes the access this cycle.
- mem_rdata, input, 32, read data; valid when mem_req & !mem_we & mem_ready.
- retire, output, 1, one-cycle pulse per completed instruction.
- trap, output, 1, sticky: illegal opcode or misaligned access.
- pc_dbg, output, ADDR_W, current architectural PC.

Behaviour:
- Reset: PC=RESET_PC, state=FETCH, all 31 GPRs=0, IR=0.
- Reset outputs: mem_req=0, mem_we=0, retire=0, trap=0.
- During an RST cycle mem_req=0; RST mid-transaction abandons the access with no writeback.
- Handshake: mem_req/mem_we/mem_addr/mem_wdata stay stable until the cycle mem_ready=1. The access completes in that cycle and the FSM advances on that edge. mem_ready while mem_req=0 is ignored.
- FETCH: mem_req=1, addr=PC. On ready, IR<=mem_rdata and PC<=PC+4 (mod 2^ADDR_W); go to DECODE.
- DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(sext(imm)<<2). Next state by opcode; any opcode outside the list below goes to TRAP.
- R-type (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A):
  - EXEC: ALUOut<=A op B; go to WB_ALU. WB_ALU: R[rd]<=ALUOut; retire.
  - Unknown funct goes to TRAP.
- addi (0x08): EXEC: ALUOut<=A+sext(imm); go to WB_ALU, which writes R[rt]. No overflow trap.
- lw (0x23):
  - EXEC: ALUOut<=A+sext(imm); go to MEM_RD.
  - MEM_RD: read at ALUOut; on ready MDR<=mem_rdata; go to WB_MEM.
  - WB_MEM: R[rt]<=MDR; retire.
- sw (0x2B): EXEC as lw, then MEM_WR. MEM_WR: write B at ALUOut; on ready retire and go to FETCH.
- beq (0x04): EXEC: if A==B then PC<=ALUOut; retire; go to FETCH.
- j (0x02): EXEC: PC<={PC[31:28], IR[25:0], 2'b00}, truncated to ADDR_W; retire.
- R0 semantics: writes to R0 are discarded; reads of R0 return 0.
- Write-then-read: a write and the next DECODE read of the same register are separated by at least one edge, so no bypass is needed.
- slt is a signed 32-bit compare; all arithmetic wraps modulo 2^32.
- Misalignment (TRAP_ON_MISALIGN=1): PC[1:0]!=0 at FETCH, or ALUOut[1:0]!=0 at EXEC for lw/sw, goes to TRAP with no memory request.
- TRAP state: trap=1 and held, mem_req=0, no further retire; left only by RST.
- Latency with zero-wait memory (ready asserted in the same cycle as req): R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
- retire is asserted in the last cycle of each instruction and is never asserted in consecutive cycles.

Decomposition:
- Package mips_mc_pkg holds:
  - opcode and funct localparams;
  - state_t enum (FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM, TRAP);
  - alu_op_t enum (ADD, SUB, AND, OR, SLT).
- One sub-module, mips_mc_regfile: 32x32, two async read ports, one sync write port, R0 forced to 0.
- ALU and FSM stay in the core.

Test Plan:
- Reset, zero-wait memory:
  - Stimulus: hold RST 2 cycles, then addi $1,$0,5; addi $2,$0,7; add $3,$1,$2.
  - Required: first mem_addr=RESET_PC; $3=12; retire pulses at cycles 4, 8, 12 after reset release.
- Load/store with wait states:
  - Stimulus: sw $3,16($0); lw $4,16($0), with mem_ready delayed 3 cycles on every access.
  - Required: write addr=0x10 with wdata=12; $4=12; lw takes 5+6=11 cycles.
- Branches:
  - Stimulus: beq $1,$1,+2 at PC 0x20; beq $1,$2,+2 at PC 0x40.
  - Required: first goes to PC 0x2C; second falls through to 0x44; j 0x100 sets PC=0x400.
- R0 and slt:
  - Stimulus: addi $0,$0,9; then slt $5,$6,$7 with $6=0xFFFFFFFF, $7=1.
  - Required: R0 reads 0; $5=1 (signed compare).
- Traps:
  - Stimulus: opcode 0x3F; separately, lw at address 0x13.
  - Required: trap=1 and sticky, mem_req=0 from then on, no retire; RST clears trap and refetches at RESET_PC.
- Reset mid-access:
  - Stimulus: assert RST while a lw waits on mem_ready.
  - Required: mem_req=0 in the RST cycle; destination register unchanged; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared opcode/funct encodings, FSM states and ALU operations
// for the multi-cycle MIPS-I subset core.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM_RD,
        MEM_WR, WB_ALU, WB_MEM, TRAP
    } state_t;

    typedef enum logic [2:0] {
        ADD, SUB, AND, OR, SLT
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two async read ports, one sync write port,
// R0 hardwired to zero.
module mips_mc_regfile (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-I subset core with a single shared memory port
// using a req/ready handshake; FETCH/DECODE/EXEC/MEM/WB sequencing.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter int               ADDR_W           = 32,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0,
    parameter bit               TRAP_ON_MISALIGN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              retire,
    output logic              trap,
    output logic [ADDR_W-1:0] pc_dbg
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir, a, b, alu_out, mdr;

    logic [5:0]  opcode, funct;
    logic [31:0] imm_ext, pc32, j_tgt, addr_calc, alu_y;
    logic [31:0] rf_rd1, rf_rd2, rf_wd;
    logic [4:0]  rf_wa;
    logic        rf_we;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j;
    logic        funct_ok, legal, fetch_mis, ea_mis;
    alu_op_t     alu_op;

    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];
    assign imm_ext   = sext16(ir[15:0]);
    assign pc32      = 32'(pc);
    assign j_tgt     = {pc32[31:28], ir[25:0], 2'b00};
    assign addr_calc = a + imm_ext;

    assign is_r    = opcode == OP_RTYPE;
    assign is_addi = opcode == OP_ADDI;
    assign is_lw   = opcode == OP_LW;
    assign is_sw   = opcode == OP_SW;
    assign is_beq  = opcode == OP_BEQ;
    assign is_j    = opcode == OP_J;

    always_comb begin
        alu_op   = ADD;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ADD;
            FN_SUB:  alu_op = SUB;
            FN_AND:  alu_op = AND;
            FN_OR:   alu_op = OR;
            FN_SLT:  alu_op = SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    assign legal = (is_r && funct_ok) || is_addi || is_lw
                || is_sw || is_beq || is_j;

    always_comb begin
        case (alu_op)
            SUB:     alu_y = a - b;
            AND:     alu_y = a & b;
            OR:      alu_y = a | b;
            SLT:     alu_y = {31'd0, $signed(a) < $signed(b)};
            default: alu_y = a + b;
        endcase
    end

    assign fetch_mis = TRAP_ON_MISALIGN && pc[1:0] != 2'b00;
    assign ea_mis    = TRAP_ON_MISALIGN && addr_calc[1:0] != 2'b00;

    // Outputs are masked during RST so an abandoned access never lingers.
    assign mem_req = !RST && ((state == FETCH && !fetch_mis)
                   || state == MEM_RD || state == MEM_WR);
    assign mem_we    = !RST && state == MEM_WR;
    assign mem_wdata = b;
    assign trap      = !RST && state == TRAP;
    assign pc_dbg    = pc;

    assign retire = !RST && (state == WB_ALU || state == WB_MEM
                  || (state == MEM_WR && mem_ready)
                  || (state == EXEC && (is_beq || is_j)));

    always_comb begin
        mem_addr = (state == FETCH) ? pc : ADDR_W'(alu_out);
        if (!TRAP_ON_MISALIGN) mem_addr[1:0] = 2'b00;
    end

    assign rf_we = !RST && (state == WB_ALU || state == WB_MEM);
    assign rf_wa = (state == WB_ALU && is_r) ? ir[15:11] : ir[20:16];
    assign rf_wd = (state == WB_MEM) ? mdr : alu_out;

    mips_mc_regfile u_rf (
        .CLK (CLK),
        .RST (RST),
        .ra1 (ir[25:21]),
        .ra2 (ir[20:16]),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (rf_wd)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (fetch_mis) begin
                        state <= TRAP;
                    end else if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + ADDR_W'(4);
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a       <= rf_rd1;
                    b       <= rf_rd2;
                    alu_out <= pc32 + (imm_ext << 2);
                    state   <= legal ? EXEC : TRAP;
                end
                EXEC: begin
                    unique case (1'b1)
                        is_r: begin
                            alu_out <= alu_y;
                            state   <= WB_ALU;
                        end
                        is_addi: begin
                            alu_out <= addr_calc;
                            state   <= WB_ALU;
                        end
                        is_lw, is_sw: begin
                            alu_out <= addr_calc;
                            if (ea_mis)     state <= TRAP;
                            else if (is_lw) state <= MEM_RD;
                            else            state <= MEM_WR;
                        end
                        is_beq: begin
                            if (a == b) pc <= ADDR_W'(alu_out);
                            state <= FETCH;
                        end
                        is_j: begin
                            pc    <= ADDR_W'(j_tgt);
                            state <= FETCH;
                        end
                        default: state <= TRAP;
                    endcase
                end
                MEM_RD: begin
                    if (mem_ready) begin
                        mdr   <= mem_rdata;
                        state <= WB_MEM;
                    end
                end
                MEM_WR: begin
                    if (mem_ready) state <= FETCH;
                end
                WB_ALU: state <= FETCH;
                WB_MEM: state <= FETCH;
                TRAP:   state <= TRAP;
            endcase
        end
    end

endmodule
